// File: rtl/demux_stream_scheduler_if.sv
// Handshake/bus bundle for demux_stream_scheduler.
//   master : upstream producer + downstream consumers (drives data/valid, config, channel readys)
//   slave  : the scheduler (drives upstream ready, channel data/valid, status)
// Signals:
//   Enable_In, Mode_In, Select_In          : configuration / per-beat steering
//   Data_In, Data_Valid_In, Data_Ready_Out : upstream valid/ready stream
//   Channel_Data_Out, Channel_Valid_Out,
//   Channel_Ready_In                       : N downstream channels
//   Active_Channel_Out, Beat_Count_Out     : round-robin status
interface demux_stream_scheduler_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SEL_WIDTH    = 2
);
  logic                               Enable_In;
  logic                               Mode_In;
  logic [SEL_WIDTH-1:0]               Select_In;
  logic [DATA_WIDTH-1:0]              Data_In;
  logic                               Data_Valid_In;
  logic                               Data_Ready_Out;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out;
  logic [NUM_CHANNELS-1:0]            Channel_Valid_Out;
  logic [NUM_CHANNELS-1:0]            Channel_Ready_In;
  logic [SEL_WIDTH-1:0]               Active_Channel_Out;
  logic [7:0]                         Beat_Count_Out;

  modport master (
    output Enable_In, Mode_In, Select_In, Data_In, Data_Valid_In, Channel_Ready_In,
    input  Data_Ready_Out, Channel_Data_Out, Channel_Valid_Out,
           Active_Channel_Out, Beat_Count_Out
  );

  modport slave (
    input  Enable_In, Mode_In, Select_In, Data_In, Data_Valid_In, Channel_Ready_In,
    output Data_Ready_Out, Channel_Data_Out, Channel_Valid_Out,
           Active_Channel_Out, Beat_Count_Out
  );
endinterface

// File: rtl/demux_stream_scheduler.sv
// Registered, handshaked 1:N stream demultiplexer. Each accepted beat is held
// in a one-entry register and steered to one channel, picked either by a
// round-robin pointer advancing every BURST_LEN beats or by a per-beat select.
// Ports:
//   Clock_In   : rising-edge clock
//   Reset_N_In : asynchronous active-low reset
//   bus        : demux_stream_scheduler_if slave (stream, channels, status)
module demux_stream_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned BURST_LEN    = 4
) (
  input  logic                     Clock_In,
  input  logic                     Reset_N_In,
  demux_stream_scheduler_if.slave  bus
);

  localparam int unsigned BusW   = NUM_CHANNELS * DATA_WIDTH;
  localparam int unsigned CntW   = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(BURST_LEN - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  tgt_q, tgt_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] vld_q, vld_d;
  logic [BusW-1:0]       dat_q, dat_d;

  logic                  full_c;
  logic                  tgt_rdy_c;
  logic                  ready_c;
  logic                  accept_c;
  logic                  deliver_c;
  logic [SEL_WIDTH-1:0]  new_tgt_c;

  // Handshake decode; ready passes straight through from the target channel
  // so a beat can be delivered and replaced in the same cycle.
  assign full_c    = (state_q == ST_FULL);
  assign tgt_rdy_c = bus.Channel_Ready_In[tgt_q];
  assign ready_c   = bus.Enable_In && (!full_c || tgt_rdy_c);
  assign accept_c  = bus.Data_Valid_In && ready_c;
  assign deliver_c = full_c && tgt_rdy_c;
  assign new_tgt_c = bus.Mode_In ? bus.Select_In : ptr_q;

  // Next-state, holding register and round-robin bookkeeping
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    dat_d   = dat_q;

    if (state_q == ST_EMPTY) begin
      if (accept_c) state_d = ST_FULL;
    end else begin
      if (deliver_c && !accept_c) state_d = ST_EMPTY;
    end

    // Channel outputs are kept pre-decoded so non-target lanes stay zero
    if (accept_c) begin
      tgt_d = new_tgt_c;
      vld_d = NUM_CHANNELS'(1) << new_tgt_c;
      dat_d = BusW'(bus.Data_In) << (new_tgt_c * DATA_WIDTH);
    end else if (deliver_c) begin
      vld_d = '0;
      dat_d = '0;
    end

    // Fixed-select beats leave the round-robin sequence untouched
    if (accept_c && !bus.Mode_In) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        ptr_d = ptr_q + SEL_WIDTH'(1);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= ST_EMPTY;
      tgt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.Data_Ready_Out     = ready_c;
  assign bus.Channel_Valid_Out  = vld_q;
  assign bus.Channel_Data_Out   = dat_q;
  assign bus.Active_Channel_Out = ptr_q;
  assign bus.Beat_Count_Out     = cnt_q;

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Directed bench for demux_stream_scheduler (DATA_WIDTH=8, 4 channels, BURST_LEN=4).
module tb_demux_stream_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned BL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_scheduler_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SEL_WIDTH(SW)) bus ();

  demux_stream_scheduler #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SEL_WIDTH(SW), .BURST_LEN(BL)
  ) dut (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic check_rr(input string tag, input int ptr, input int cnt);
    to_sample();
    check({tag, "_ptr"}, 32'(bus.Active_Channel_Out), 32'(ptr));
    check({tag, "_cnt"}, 32'(bus.Beat_Count_Out), 32'(cnt));
    to_drive();
  endtask

  // One isolated beat with all readys high: accept, show on channel ch, deliver.
  task automatic send_one(input logic [7:0] d, input logic m, input logic [1:0] s,
                          input int ch, input string tag);
    bus.Data_In       = d;
    bus.Mode_In       = m;
    bus.Select_In     = s;
    bus.Data_Valid_In = 1'b1;
    to_sample();
    check({tag, "_rdy"}, 32'(bus.Data_Ready_Out), 32'd1);
    to_drive();
    bus.Data_Valid_In = 1'b0;
    bus.Select_In     = ~s;
    to_sample();
    check({tag, "_vld"}, 32'(bus.Channel_Valid_Out), 32'd1 << ch);
    check({tag, "_dat"}, 32'(bus.Channel_Data_Out), 32'(d) << (ch * 8));
    to_drive();
  endtask

  initial begin
    logic [1:0] fsel [4];
    fsel[0] = 2'd3; fsel[1] = 2'd1; fsel[2] = 2'd1; fsel[3] = 2'd0;

    bus.Enable_In        = 1'b0;
    bus.Mode_In          = 1'b0;
    bus.Select_In        = '0;
    bus.Data_In          = '0;
    bus.Data_Valid_In    = 1'b0;
    bus.Channel_Ready_In = 4'hF;

    // Reset state
    #12;
    check("rst_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    check("rst_dat", 32'(bus.Channel_Data_Out), 32'd0);
    check("rst_rdy", 32'(bus.Data_Ready_Out), 32'd0);
    check("rst_ptr", 32'(bus.Active_Channel_Out), 32'd0);
    check("rst_cnt", 32'(bus.Beat_Count_Out), 32'd0);
    to_drive();
    rst_n         = 1'b1;
    bus.Enable_In = 1'b1;

    // Round-robin: 16 back-to-back beats, four per channel
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        bus.Data_Valid_In = 1'b1;
        bus.Data_In       = 8'(i);
      end else begin
        bus.Data_Valid_In = 1'b0;
      end
      to_sample();
      if (i < 16) check("rr_rdy", 32'(bus.Data_Ready_Out), 32'd1);
      if (i > 0) begin
        int j;
        int ch;
        j  = i - 1;
        ch = j / 4;
        check("rr_vld", 32'(bus.Channel_Valid_Out), 32'd1 << ch);
        check("rr_dat", 32'(bus.Channel_Data_Out), 32'(j) << (ch * 8));
      end
      if (i == 6) begin
        check("rr_mid_ptr", 32'(bus.Active_Channel_Out), 32'd1);
        check("rr_mid_cnt", 32'(bus.Beat_Count_Out), 32'd2);
      end
      to_drive();
    end
    to_sample();
    check("rr_end_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    check("rr_end_ptr", 32'(bus.Active_Channel_Out), 32'd0);
    check("rr_end_cnt", 32'(bus.Beat_Count_Out), 32'd0);
    to_drive();

    // Fixed select: 3,1,1,0
    for (int i = 0; i < 4; i++) begin
      send_one(8'hA0 + 8'(i), 1'b1, fsel[i], int'(fsel[i]), "fix");
    end
    check_rr("fix_end", 0, 0);

    // Backpressure: ch1 held 5 cycles, then deliver + accept together
    bus.Channel_Ready_In = 4'b1101;
    bus.Mode_In          = 1'b1;
    bus.Select_In        = 2'd1;
    bus.Data_In          = 8'h55;
    bus.Data_Valid_In    = 1'b1;
    to_sample();
    check("bp_acc_rdy", 32'(bus.Data_Ready_Out), 32'd1);
    to_drive();
    bus.Data_In   = 8'h66;
    bus.Select_In = 2'd2;
    for (int k = 0; k < 5; k++) begin
      to_sample();
      check("bp_vld", 32'(bus.Channel_Valid_Out), 32'b0010);
      check("bp_dat", 32'(bus.Channel_Data_Out), 32'h0000_5500);
      check("bp_rdy", 32'(bus.Data_Ready_Out), 32'd0);
      to_drive();
    end
    bus.Channel_Ready_In = 4'hF;
    to_sample();
    check("bp_rel_rdy", 32'(bus.Data_Ready_Out), 32'd1);
    check("bp_rel_vld", 32'(bus.Channel_Valid_Out), 32'b0010);
    to_drive();
    bus.Data_Valid_In = 1'b0;
    to_sample();
    check("bp_next_vld", 32'(bus.Channel_Valid_Out), 32'b0100);
    check("bp_next_dat", 32'(bus.Channel_Data_Out), 32'h0066_0000);
    to_drive();
    to_sample();
    check("bp_idle_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    to_drive();

    // Enable drop while FULL
    bus.Mode_In          = 1'b0;
    bus.Channel_Ready_In = 4'b1110;
    bus.Data_In          = 8'h10;
    bus.Data_Valid_In    = 1'b1;
    to_sample();
    check("en_acc_rdy", 32'(bus.Data_Ready_Out), 32'd1);
    to_drive();
    bus.Enable_In = 1'b0;
    bus.Data_In   = 8'h12;
    to_sample();
    check("en_hold_vld", 32'(bus.Channel_Valid_Out), 32'b0001);
    check("en_hold_rdy", 32'(bus.Data_Ready_Out), 32'd0);
    to_drive();
    bus.Channel_Ready_In = 4'hF;
    to_sample();
    check("en_dlv_rdy", 32'(bus.Data_Ready_Out), 32'd0);
    check("en_dlv_vld", 32'(bus.Channel_Valid_Out), 32'b0001);
    to_drive();
    to_sample();
    check("en_idle_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    check("en_idle_cnt", 32'(bus.Beat_Count_Out), 32'd1);
    check("en_idle_ptr", 32'(bus.Active_Channel_Out), 32'd0);
    to_drive();
    to_sample();
    check("en_idle2_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    to_drive();
    bus.Enable_In = 1'b1;
    to_sample();
    check("en_re_rdy", 32'(bus.Data_Ready_Out), 32'd1);
    to_drive();
    bus.Data_Valid_In = 1'b0;
    to_sample();
    check("en_re_vld", 32'(bus.Channel_Valid_Out), 32'b0001);
    check("en_re_dat", 32'(bus.Channel_Data_Out), 32'h0000_0012);
    check("en_re_cnt", 32'(bus.Beat_Count_Out), 32'd2);
    to_drive();

    // Reset mid-transfer with a beat held for ch2
    bus.Mode_In          = 1'b1;
    bus.Select_In        = 2'd2;
    bus.Channel_Ready_In = 4'b1011;
    bus.Data_In          = 8'h77;
    bus.Data_Valid_In    = 1'b1;
    to_sample();
    check("mr_acc_rdy", 32'(bus.Data_Ready_Out), 32'd1);
    to_drive();
    bus.Data_Valid_In = 1'b0;
    to_sample();
    check("mr_full_vld", 32'(bus.Channel_Valid_Out), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    check("mr_dat", 32'(bus.Channel_Data_Out), 32'd0);
    check("mr_ptr", 32'(bus.Active_Channel_Out), 32'd0);
    check("mr_cnt", 32'(bus.Beat_Count_Out), 32'd0);
    to_drive();
    bus.Channel_Ready_In = 4'hF;
    rst_n = 1'b1;
    to_sample();
    check("mr_post_vld", 32'(bus.Channel_Valid_Out), 32'd0);
    to_drive();

    // Mode interleave: 2 RR, 3 fixed, 2 RR
    send_one(8'h20, 1'b0, 2'd0, 0, "mix_rr0");
    send_one(8'h21, 1'b0, 2'd0, 0, "mix_rr1");
    check_rr("mix_a", 0, 2);
    send_one(8'h30, 1'b1, 2'd2, 2, "mix_fx0");
    send_one(8'h31, 1'b1, 2'd3, 3, "mix_fx1");
    send_one(8'h32, 1'b1, 2'd1, 1, "mix_fx2");
    check_rr("mix_b", 0, 2);
    send_one(8'h22, 1'b0, 2'd0, 0, "mix_rr2");
    check_rr("mix_c", 0, 3);
    send_one(8'h23, 1'b0, 2'd0, 0, "mix_rr3");
    check_rr("mix_d", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_stream_scheduler.md
# demux_stream_scheduler

Sequencing controller that distributes a single valid/ready data stream across `NUM_CHANNELS` output channels, acting as a registered, handshaked 1:N demultiplexer. Each accepted beat is captured into a one-entry holding register and steered to exactly one channel. The target is chosen either by a round-robin pointer that advances every `BURST_LEN` beats, or by a per-beat `Select_In` value. It sits between a single upstream producer and N independent downstream consumers.

## Interface
- `DATA_WIDTH`, 8, width of each data beat.
- `NUM_CHANNELS`, 4, number of output channels; must be a power of two, at least 2.
- `SEL_WIDTH`, 2, log2(`NUM_CHANNELS`).
- `BURST_LEN`, 4, beats per channel before the round-robin pointer advances; range 1..255.

Ports:
- `Clock_In` in 1: single clock, rising edge.
- `Reset_N_In` in 1: asynchronous, active-low reset.
- `Enable_In` in 1: when 0, no new beats are accepted; a beat already held still completes.
- `Mode_In` in 1: 0 selects round-robin, 1 selects fixed select.
- `Select_In` in `SEL_WIDTH`: target channel in fixed mode; sampled on beat acceptance.
- `Data_In` in `DATA_WIDTH`: upstream data.
- `Data_Valid_In` in 1: upstream valid.
- `Data_Ready_Out` out 1: upstream ready.
- `Channel_Data_Out` out `NUM_CHANNELS*DATA_WIDTH`: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `Channel_Valid_Out` out `NUM_CHANNELS`: one-hot or all-zero.
- `Channel_Ready_In` in `NUM_CHANNELS`: per-channel downstream ready.
- `Active_Channel_Out` out `SEL_WIDTH`: current round-robin pointer.
- `Beat_Count_Out` out 8: beats accepted in the current round-robin burst.

## Operation
- The FSM has two states:
  - EMPTY: the holding register is invalid.
  - FULL: the holding register contains a beat with a registered target `tgt`.
- A beat is accepted when `Data_Valid_In && Data_Ready_Out`.
- `Data_Ready_Out` = `Enable_In && (EMPTY || (FULL && Channel_Ready_In[tgt]))`. This is a combinational path from `Channel_Ready_In[tgt]`, which allows one beat per cycle.
- A beat is delivered when `FULL && Channel_Ready_In[tgt]`.
- State transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on deliver without accept.
  - FULL stays FULL on simultaneous deliver and accept; the register reloads with the new beat and new target.
  - Otherwise the state holds.
- Target on accept:
  - Mode 1: `tgt` = `Select_In`.
  - Mode 0: `tgt` = pointer.
- Round-robin bookkeeping, updated only on accepts in mode 0:
  - If `Beat_Count_Out == BURST_LEN-1`: count goes to 0 and the pointer goes to pointer+1, wrapping modulo `NUM_CHANNELS`.
  - Otherwise the count increments.
- Accepts in mode 1 leave the pointer and count unchanged. The round-robin sequence resumes where it left off when `Mode_In` returns to 0.
- Outputs:
  - `Channel_Valid_Out[k]` = FULL && (k == `tgt`).
  - `Channel_Data_Out` for k == `tgt` is the held data while FULL. Every non-target channel, and every channel while EMPTY, is driven to all-zero; outputs are never high-Z.
- Data is never dropped or duplicated. A held beat stays stable on its channel until that channel's ready is seen high; downstream stalls are unbounded.
- When `Enable_In` falls, the held beat still delivers, after which the block idles in EMPTY. The pointer and count are retained.

## Timing
- Reset (async assert, released synchronously to `Clock_In` by the integrator) forces:
  - state EMPTY;
  - `Channel_Valid_Out` = 0, `Channel_Data_Out` = 0, `Data_Ready_Out` = 0 (because EMPTY with Enable is not required; ready follows `Enable_In`);
  - pointer 0, `Beat_Count_Out` 0, `Active_Channel_Out` 0.
- Reset asserted mid-transfer discards the held beat immediately. Nothing is delivered after reset.
- Latency from accept on edge N to `Channel_Valid_Out` high is visible after edge N, i.e. one cycle.
- Throughput is one beat per cycle while the target channels keep ready high.
- `Select_In` and `Mode_In` are sampled only on an accepting edge; changes between accepts have no effect on a beat already held.
- Boundary cases:
  - `BURST_LEN` = 1 advances the pointer on every accept.
  - The pointer wraps from `NUM_CHANNELS-1` to 0.
  - A stalled target channel blocks all channels (head-of-line). This is intended.

## Test plan
- **Reset:** drive `Reset_N_In`=0 mid-transfer with FULL on channel 2 -> same cycle, all `Channel_Valid_Out`=0, data=0, pointer=0, count=0.
- **Round-robin:** mode 0, `BURST_LEN`=4, 16 back-to-back beats 0x00..0x0F, all readys high -> beats 0..3 on ch0, 4..7 on ch1, 8..11 on ch2, 12..15 on ch3. Pointer then wraps to 0, and the final beat is delivered one cycle after its accept.
- **Fixed select:** mode 1, `Select_In` = 3,1,1,0 with beats 0xA0..0xA3 -> delivered on ch3, ch1, ch1, ch0. Pointer and count are unchanged.
- **Backpressure:** target ch1 ready low for 5 cycles with beat 0x55 held -> `Channel_Valid_Out`=4'b0010 and data stable for all 5 cycles; `Data_Ready_Out`=0. The next cycle delivers the beat and accepts the next beat simultaneously.
- **Enable drop:** deassert `Enable_In` while FULL -> held beat delivers, `Data_Ready_Out` stays 0, and no further accepts occur. On reenable, round-robin continues from the retained pointer and count.
- **Mode interleave:** 2 round-robin beats, 3 fixed-select beats, then 2 round-robin beats -> round-robin beats land on ch0 four times total and count reaches 3 with no reset of the sequence.
